// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding and default timeout.
package fetch_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_EXEC,
        ST_UPDATE,
        ST_HALTED
    } state_t;

endpackage

// File: rtl/timeout_counter.sv
// Counts consecutive un-acknowledged fetch cycles; o_expired flags the TIMEOUT-th one.
module timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + W'(1);
        end
    end

    // Current cycle is already the TIMEOUT-th miss when LAST misses preceded it.
    assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/fetch_controller.sv
// Fetch/execute sequencing FSM: fetch with timeout, wait for datapath, update PC, count retirements.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             run,
    input  logic             halt_req,
    input  logic             imem_ack,
    input  logic             exec_done,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             ir_load,
    output logic             instr_valid,
    output logic             pc_load,
    output logic             pc_src,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    logic             r_pc_src;
    logic             r_fault;
    logic [CNT_W-1:0] r_retired;

    logic w_in_fetch;
    logic w_tmo_clear;
    logic w_tmo_enable;
    logic w_expired;

    assign w_in_fetch   = (r_state == ST_FETCH);
    assign w_tmo_clear  = !w_in_fetch || imem_ack;
    assign w_tmo_enable = w_in_fetch && !imem_ack;

    timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_enable),
        .o_expired(w_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_pc_src  <= 1'b0;
            r_fault   <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (halt_req) begin
                        r_state <= ST_HALTED;
                    end else if (run) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // An ack in the expiry cycle still wins over the timeout.
                    if (imem_ack) begin
                        r_state <= ST_WAIT_EXEC;
                    end else if (w_expired) begin
                        r_fault <= 1'b1;
                        r_state <= ST_HALTED;
                    end
                end
                ST_WAIT_EXEC: begin
                    if (exec_done) begin
                        r_pc_src <= branch_taken;
                        r_state  <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_retired <= r_retired + CNT_W'(1);
                    r_state   <= halt_req ? ST_HALTED : ST_FETCH;
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = w_in_fetch;
    assign ir_load     = w_in_fetch && imem_ack;
    assign instr_valid = (r_state == ST_WAIT_EXEC);
    assign pc_load     = (r_state == ST_UPDATE);
    assign halted      = (r_state == ST_HALTED);
    assign pc_src      = r_pc_src;
    assign fault       = r_fault;
    assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed scenarios plus random traffic against a reference model.
module tb_fetch_controller;

    localparam int unsigned TMO = 4;
    localparam int unsigned CW  = 4;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_UPD   = 3;
    localparam int P_HALT  = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          run = 1'b0;
    logic          halt_req = 1'b0;
    logic          imem_ack = 1'b0;
    logic          exec_done = 1'b0;
    logic          branch_taken = 1'b0;
    logic          imem_req, ir_load, instr_valid, pc_load, pc_src, halted, fault;
    logic [CW-1:0] retired;

    always #5 CLK = ~CLK;

    fetch_controller #(
        .TIMEOUT(TMO),
        .CNT_W  (CW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .run         (run),
        .halt_req    (halt_req),
        .imem_ack    (imem_ack),
        .exec_done   (exec_done),
        .branch_taken(branch_taken),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .instr_valid (instr_valid),
        .pc_load     (pc_load),
        .pc_src      (pc_src),
        .halted      (halted),
        .fault       (fault),
        .retired     (retired)
    );

    // Output vector: {imem_req, ir_load, instr_valid, pc_load, pc_src, halted, fault, retired}
    typedef logic [10:0] vec_t;
    vec_t exp_q[$];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model: phase of the current instruction, misses so far, sticky flags, retire count.
    int m_phase = P_IDLE;
    int m_wait  = 0;
    bit m_br    = 1'b0;
    bit m_fault = 1'b0;
    int m_ret   = 0;

    function automatic vec_t exp_out(input bit a);
        bit fetching;
        fetching = (m_phase == P_FETCH);
        return {fetching, fetching && a, m_phase == P_EXEC, m_phase == P_UPD,
                m_br, m_phase == P_HALT, m_fault, 4'(m_ret)};
    endfunction

    task automatic model_step(input bit rst, input bit r, input bit h, input bit a,
                              input bit d, input bit b);
        if (rst) begin
            m_phase = P_IDLE;
            m_wait  = 0;
            m_br    = 1'b0;
            m_fault = 1'b0;
            m_ret   = 0;
        end else begin
            case (m_phase)
                P_IDLE:  if (h) m_phase = P_HALT; else if (r) m_phase = P_FETCH;
                P_FETCH: begin
                    if (a) begin
                        m_wait  = 0;
                        m_phase = P_EXEC;
                    end else begin
                        m_wait = m_wait + 1;
                        if (m_wait >= int'(TMO)) begin
                            m_fault = 1'b1;
                            m_phase = P_HALT;
                        end
                    end
                end
                P_EXEC:  if (d) begin m_br = b; m_phase = P_UPD; end
                P_UPD: begin
                    m_ret   = (m_ret + 1) % (1 << CW);
                    m_phase = h ? P_HALT : P_FETCH;
                end
                default: m_phase = m_phase;
            endcase
        end
    endtask

    task automatic cycle(input bit rst, input bit r, input bit h, input bit a,
                         input bit d, input bit b, input bit chk);
        @(posedge CLK);
        #1;
        RST = rst; run = r; halt_req = h; imem_ack = a; exec_done = d; branch_taken = b;
        if (chk) exp_q.push_back(exp_out(a));
        model_step(rst, r, h, a, d, b);
    endtask

    task automatic cyc(input bit r, input bit h, input bit a, input bit d, input bit b);
        cycle(1'b0, r, h, a, d, b, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    always @(negedge CLK) begin
        vec_t e, got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {imem_req, ir_load, instr_valid, pc_load, pc_src, halted, fault, retired};
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL vec%0d t=%0t {req,irl,iv,pcl,src,hlt,flt,ret}: got=%b exp=%b",
                         n_vec, $time, got, e);
            end
        end
    end

    initial begin
        // DUT state is undefined before the first reset edge, so that cycle is not scored.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        cyc(0, 0, 0, 0, 0);

        // Basic instruction: ack after 3 misses (no fault at TIMEOUT=4), straight-line update.
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Taken branch, then pc_src must hold 1 through the next fetch/exec.
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // Halt requested while executing: instruction completes, then halts.
        cyc(0, 1, 1, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(1, 0, 1, 1, 1);

        // Timeout: four missed cycles fault and halt; reset clears it.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        repeat (TMO) cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(1, 1, 1, 1, 0);
        do_reset();
        cyc(0, 0, 0, 0, 0);

        // Reset mid-fetch.
        cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        do_reset();
        cyc(0, 0, 0, 0, 0);

        // Halt from IDLE has priority over run.
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        do_reset();

        // Counter wrap: 17 retirements with a 4-bit counter.
        cyc(1, 0, 0, 0, 0);
        repeat (17) begin
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);

        // Random traffic.
        repeat (3000) begin
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  1'b1);
        end

        repeat (3) @(negedge CLK);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
